// File: rtl/i_type_decode_if.sv
// i_type_decode_if: handshake bundle between the instruction source, the
// I-type decoder and the execute stage.
//   in_valid/in_ready/instr             : instruction word into the decoder
//   out_valid/out_ready/r1/r3/imm/ctrl  : decoded fields out to execute
// slave  = decoder side, master = the environment driving/consuming it.
interface i_type_decode_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  r1;
   logic [4:0]  r3;
   logic [11:0] imm;
   logic [5:0]  ctrl;

   modport slave (
      input  in_valid, instr, out_ready,
      output in_ready, out_valid, r1, r3, imm, ctrl
   );

   modport master (
      output in_valid, instr, out_ready,
      input  in_ready, out_valid, r1, r3, imm, ctrl
   );
endinterface

// File: rtl/i_type_decode.sv
// i_type_decode: buffers I-type instruction words in a DEPTH-entry FIFO and
// decodes the head into the execute stage's r1/r3/imm/ctrl output register.
// Illegal words (unknown opcode or nonzero reserved bits) are discarded,
// pulsed on illegal and counted (saturating) in illegal_cnt.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush         : clears FIFO and output register, keeps illegal_cnt
//   bus (slave)   : in_valid/in_ready/instr, out_valid/out_ready/r1/r3/imm/ctrl
//   illegal       : one-cycle pulse after an illegal word is dropped
//   illegal_cnt   : saturating count of dropped words
//   fifo_count    : current FIFO occupancy
module i_type_decode #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   i_type_decode_if.slave           bus,
   output logic                     illegal,
   output logic [CNT_W-1:0]         illegal_cnt,
   output logic [$clog2(DEPTH):0]   fifo_count
);
   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0][31:0] mem_q, mem_d;
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]            count_q, count_d;
   logic                   out_valid_q, out_valid_d;
   logic [4:0]             r1_q, r1_d, r3_q, r3_d;
   logic [11:0]            imm_q, imm_d;
   logic [5:0]             ctrl_q, ctrl_d;
   logic                   illegal_q, illegal_d;
   logic [CNT_W-1:0]       illegal_cnt_q, illegal_cnt_d;

   logic        full, empty, push, pop, legal;
   logic [31:0] head;
   logic [5:0]  dec_ctrl;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];

   // Opcode -> ALU control; reserved field must be zero for a legal word.
   always_comb begin
      legal    = 1'b1;
      dec_ctrl = '0;
      case (head[31:26])
         6'd14:   dec_ctrl = 6'b100000; // ADDI
         6'd8:    dec_ctrl = 6'b101000; // SUBI
         6'd28:   dec_ctrl = 6'b100111; // ANDI
         6'd24:   dec_ctrl = 6'b100110; // ORI
         6'd30:   dec_ctrl = 6'b101111; // NORI
         6'd31:   dec_ctrl = 6'b101110; // NANDI
         default: legal    = 1'b0;
      endcase
      if (head[15:12] != 4'd0) legal = 1'b0;
   end

   // in_ready is !full even while a pop is pending: no push-through when full.
   assign push = bus.in_valid && !full && !flush;
   assign pop  = !empty && (!out_valid_q || bus.out_ready) && !flush;

   always_comb begin
      mem_d         = mem_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      out_valid_d   = out_valid_q;
      r1_d          = r1_q;
      r3_d          = r3_q;
      imm_d         = imm_q;
      ctrl_d        = ctrl_q;
      illegal_d     = 1'b0;
      illegal_cnt_d = illegal_cnt_q;

      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         out_valid_d = 1'b0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_d] = bus.instr;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            if (legal) begin
               out_valid_d = 1'b1;
               r1_d        = head[25:21];
               r3_d        = head[20:16];
               imm_d       = head[11:0];
               ctrl_d      = dec_ctrl;
            end else begin
               // Current output (if any) is consumed; nothing replaces it.
               out_valid_d = out_valid_q && !bus.out_ready;
               illegal_d   = 1'b1;
               if (illegal_cnt_q != '1) illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
            end
         end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
         end
         if (push && !pop)      count_d = count_q + (AW+1)'(1);
         else if (pop && !push) count_d = count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q         <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         out_valid_q   <= 1'b0;
         r1_q          <= '0;
         r3_q          <= '0;
         imm_q         <= '0;
         ctrl_q        <= '0;
         illegal_q     <= 1'b0;
         illegal_cnt_q <= '0;
      end else begin
         mem_q         <= mem_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         out_valid_q   <= out_valid_d;
         r1_q          <= r1_d;
         r3_q          <= r3_d;
         imm_q         <= imm_d;
         ctrl_q        <= ctrl_d;
         illegal_q     <= illegal_d;
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

   assign bus.in_ready  = !full;
   assign bus.out_valid = out_valid_q;
   assign bus.r1        = r1_q;
   assign bus.r3        = r3_q;
   assign bus.imm       = imm_q;
   assign bus.ctrl      = ctrl_q;
   assign illegal       = illegal_q;
   assign illegal_cnt   = illegal_cnt_q;
   assign fifo_count    = count_q;
endmodule

// File: doc/i_type_decode.md
Name: i_type_decode

Overview:
Decode stage directly upstream of the I-type execute block. It accepts 32-bit I-type instruction words over a valid/ready handshake and buffers them in a small FIFO. Each word is decoded into the execute block's inputs: source register address r1, destination address r3, 12-bit immediate imm and 6-bit ALU control ctrl. These are presented in an output register with valid/ready. Illegal encodings are dropped, flagged and counted.

Parameters:
DEPTH, 4, input FIFO entries; power of 2, minimum 2
CNT_W, 8, width of illegal-instruction counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  synchronous clear of FIFO and output register; counter kept
in_valid  input  1  instr is valid
in_ready  output  1  FIFO can accept; equals !full
instr  input  32  instruction word
out_valid  output  1  decoded fields valid
out_ready  input  1  execute stage consumes this cycle
r1  output  5  rs1 address, instr[25:21]
r3  output  5  rd address, instr[20:16]
imm  output  12  instr[11:0], passed unextended (execute stage sign-extends)
ctrl  output  6  ALU control code
illegal  output  1  one-cycle pulse: an illegal word was discarded
illegal_cnt  output  CNT_W  saturating count of discarded words
fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Instruction format: [31:26] opcode, [25:21] rs1, [20:16] rd, [15:12] reserved (must be 0), [11:0] imm.
- Opcode to ctrl map:
  - 14 ADDI -> 100000
  - 8 SUBI -> 101000
  - 28 ANDI -> 100111
  - 24 ORI -> 100110
  - 30 NORI -> 101111
  - 31 NANDI -> 101110
  - Any other opcode, or nonzero reserved bits, is illegal.
- Reset (rst=1 at an edge): FIFO empty, fifo_count=0, out_valid=0, r1=r3=0, imm=0, ctrl=0, illegal=0, illegal_cnt=0. in_ready=1 in the cycle after reset. Reset mid-operation discards all buffered and presented words.
- Push: when in_valid && in_ready at an edge, instr is written at the tail. A push is never permitted when full, even if a pop occurs the same cycle.
- Pop condition: FIFO non-empty && (!out_valid || out_ready). When it holds, the head is popped and decoded that edge.
  - Legal head: the output register loads r1, r3, imm and ctrl; out_valid=1.
  - Illegal head: out_valid is cleared if out_ready, otherwise held; illegal=1 for the next cycle; illegal_cnt increments, saturating at all-ones.
- Hold: while out_valid && !out_ready, all output fields and out_valid stay stable.
- Latency: a word accepted at edge k appears with out_valid=1 after edge k+1 at the earliest. Throughput is one instruction per cycle when out_ready is held high.
- Simultaneous push and pop: fifo_count is unchanged. Pointers wrap modulo DEPTH.
- Empty with out_ready=1: out_valid drops to 0 at the edge; fields keep their last values.
- flush=1 at an edge: FIFO empties, out_valid=0, illegal=0, illegal_cnt kept. A push in the same cycle is dropped. rst has priority over flush.

Test Plan:
- ADDI: instr=0x38470FFA, out_ready=1 -> two edges later out_valid=1, r1=2, r3=7, imm=0xFFA, ctrl=100000.
- Stream one word per cycle: SUBI(r1=1, imm=2), ANDI, ORI, NORI, NANDI -> ctrl sequence 101000, 100111, 100110, 101111, 101110 on consecutive cycles; fifo_count never exceeds 1.
- Backpressure: out_ready=0, push 5 legal words, DEPTH=4 -> first word held at the output, then 4 in FIFO, in_ready=0 and the 6th word refused. out_ready=1 -> all 5 drain in order, one per cycle.
- Illegal: opcode 63, then instr 0x38471FFA (reserved=1) -> each discarded, illegal pulses twice, illegal_cnt=2, nothing presented. With 255 illegal words illegal_cnt stays 255.
- Mid-operation: 3 words buffered, assert flush -> fifo_count=0, out_valid=0, illegal_cnt unchanged. Repeat with rst -> illegal_cnt=0.
- Pointer wrap: 10 words pushed and popped continuously -> output order is preserved across the wrap.
